// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single strobe/busy memory. One-cycle requester
// strobes are latched per port so a losing requester waits with busy high.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wmask,
  input  logic        s0_rstrb,
  output logic [31:0] s0_rdata,
  output logic        s0_rbusy,
  output logic        s0_wbusy,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wmask,
  input  logic        s1_rstrb,
  output logic [31:0] s1_rdata,
  output logic        s1_rbusy,
  output logic        s1_wbusy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  state_e state_q, state_d;

  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic [3:0]  in_wmask [2];
  logic [1:0]  in_req;

  assign in_addr[0]  = s0_addr;
  assign in_addr[1]  = s1_addr;
  assign in_wdata[0] = s0_wdata;
  assign in_wdata[1] = s1_wdata;
  assign in_wmask[0] = s0_wmask;
  assign in_wmask[1] = s1_wmask;
  assign in_req      = {s1_rstrb | (|s1_wmask), s0_rstrb | (|s0_wmask)};

  logic [1:0]  pend_q, is_wr_q, set_pend, clr_pend, rdata_we;
  logic [31:0] addr_q  [2];
  logic [31:0] wdata_q [2];
  logic [3:0]  wmask_q [2];
  logic [31:0] rdata_q [2];
  logic        grant_q, grant_d, last_grant_q, last_grant_d, win;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  // A strobe is only captured into an empty slot; wmask wins over rstrb.
  assign set_pend = in_req & ~pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      is_wr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        wmask_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      pend_q <= (pend_q | set_pend) & ~clr_pend;
      for (int i = 0; i < 2; i++) begin
        if (set_pend[i]) begin
          is_wr_q[i] <= |in_wmask[i];
          addr_q[i]  <= in_addr[i];
          wdata_q[i] <= in_wdata[i];
          wmask_q[i] <= in_wmask[i];
        end
        if (rdata_we[i]) rdata_q[i] <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    clr_pend     = '0;
    rdata_we     = '0;
    mem_rstrb    = 1'b0;
    mem_wmask    = 4'h0;
    win          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          if (&pend_q) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
          else         win = pend_q[1];
          grant_d      = win;
          last_grant_d = win;
          mem_addr_d   = addr_q[win];
          mem_wdata_d  = wdata_q[win];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        mem_rstrb = ~is_wr_q[grant_q];
        mem_wmask = is_wr_q[grant_q] ? wmask_q[grant_q] : 4'h0;
        state_d   = StWait;
      end
      StWait: begin
        if (is_wr_q[grant_q] ? !mem_wbusy : !mem_rbusy) begin
          clr_pend[grant_q] = 1'b1;
          rdata_we[grant_q] = ~is_wr_q[grant_q];
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign s0_rdata  = rdata_q[0];
  assign s1_rdata  = rdata_q[1];
  assign s0_rbusy  = pend_q[0] & ~is_wr_q[0];
  assign s0_wbusy  = pend_q[0] & is_wr_q[0];
  assign s1_rbusy  = pend_q[1] & ~is_wr_q[1];
  assign s1_wbusy  = pend_q[1] & is_wr_q[1];

  // A strobe while the port is still pending is dropped by the datapath; flag it in simulation.
  a_s0_no_overrun: assert property (@(posedge clk) disable iff (reset) !(pend_q[0] && in_req[0]))
    else $error("mem_arbiter: port 0 strobe ignored while request pending");
  a_s1_no_overrun: assert property (@(posedge clk) disable iff (reset) !(pend_q[1] && in_req[1]))
    else $error("mem_arbiter: port 1 strobe ignored while request pending");

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle, plus
// directed literal checks and a fixed-priority instance for tie-break order.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s0_addr = '0, s1_addr = '0, s0_wdata = '0, s1_wdata = '0;
  logic [3:0]  s0_wmask = '0, s1_wmask = '0;
  logic        s0_rstrb = 1'b0, s1_rstrb = 1'b0;

  logic [31:0] s0_rdata, s1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        s0_rbusy, s1_rbusy, s0_wbusy, s1_wbusy, mem_rstrb, mem_rbusy, mem_wbusy;
  logic [3:0]  mem_wmask;

  logic [31:0] f_s0_rdata, f_s1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic        f_s0_rbusy, f_s1_rbusy, f_s0_wbusy, f_s1_wbusy, f_mem_rstrb;
  logic        f_mem_rbusy, f_mem_wbusy;
  logic [3:0]  f_mem_wmask;
  assign f_mem_rdata = 32'h0;
  assign f_mem_rbusy = 1'b0;
  assign f_mem_wbusy = 1'b0;
  assign mem_wbusy   = 1'b0;

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wmask(s0_wmask), .s0_rstrb(s0_rstrb),
    .s0_rdata(s0_rdata), .s0_rbusy(s0_rbusy), .s0_wbusy(s0_wbusy),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wmask(s1_wmask), .s1_rstrb(s1_rstrb),
    .s1_rdata(s1_rdata), .s1_rbusy(s1_rbusy), .s1_wbusy(s1_wbusy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wmask(s0_wmask), .s0_rstrb(s0_rstrb),
    .s0_rdata(f_s0_rdata), .s0_rbusy(f_s0_rbusy), .s0_wbusy(f_s0_wbusy),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wmask(s1_wmask), .s1_rstrb(s1_rstrb),
    .s1_rdata(f_s1_rdata), .s1_rbusy(f_s1_rbusy), .s1_wbusy(f_s1_wbusy),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
    .mem_rstrb(f_mem_rstrb), .mem_rdata(f_mem_rdata), .mem_rbusy(f_mem_rbusy),
    .mem_wbusy(f_mem_wbusy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rd_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      32'h100 >> 2: return 32'hDEADBEEF;
      32'h10 >> 2:  return 32'h11111111;
      32'h20 >> 2:  return 32'h22222222;
      32'h40 >> 2:  return 32'h12345678;
      default:      return 32'(i) * 32'h01010101;
    endcase
  endfunction

  // Memory seen by the main instance; rbusy stays high for rd_stall cycles after a read strobe.
  logic [31:0] mem [256];
  bit          mem_loaded = 1'b0;
  int          mem_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rbusy <= 1'b0;
      mem_rdata <= '0;
      mem_cnt   <= 0;
      if (!mem_loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      if (mem_rstrb) begin
        mem_rdata <= mem[mem_addr[9:2]];
        mem_cnt   <= rd_stall;
        mem_rbusy <= (rd_stall != 0);
      end else if (mem_cnt > 0) begin
        mem_cnt   <= mem_cnt - 1;
        mem_rbusy <= (mem_cnt > 1);
      end
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: per-port request slots and one server walking grant, issue, wait.
  logic [1:0]  m_pend, m_wr;
  logic [31:0] m_a [2];
  logic [31:0] m_d [2];
  logic [3:0]  m_m [2];
  logic [31:0] m_rdata [2];
  logic [31:0] m_mem [256];
  logic [31:0] m_snap, m_cur_addr, m_cur_wdata;
  logic        m_last, m_port;
  int          m_srv, m_left;
  bit          m_loaded = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    logic [1:0] cap;
    logic       w;
    if (reset) begin
      m_pend      <= '0;
      m_wr        <= '0;
      m_rdata[0]  <= '0;
      m_rdata[1]  <= '0;
      m_last      <= 1'b1;
      m_port      <= 1'b0;
      m_srv       <= 0;
      m_left      <= 0;
      m_snap      <= '0;
      m_cur_addr  <= '0;
      m_cur_wdata <= '0;
      if (!m_loaded) begin
        for (int i = 0; i < 256; i++) m_mem[i] <= init_word(i);
        m_loaded <= 1'b1;
      end
    end else begin
      cap[0] = !m_pend[0] && (s0_rstrb || s0_wmask != 0);
      cap[1] = !m_pend[1] && (s1_rstrb || s1_wmask != 0);
      if (m_srv == 0) begin
        if (m_pend != 2'b00) begin
          w = (m_pend == 2'b11) ? ~m_last : m_pend[1];
          m_port      <= w;
          m_last      <= w;
          m_cur_addr  <= m_a[w];
          m_cur_wdata <= m_d[w];
          m_srv       <= 1;
        end
      end else if (m_srv == 1) begin
        if (m_wr[m_port]) begin
          for (int b = 0; b < 4; b++)
            if (m_m[m_port][b]) m_mem[m_cur_addr[9:2]][8*b +: 8] <= m_cur_wdata[8*b +: 8];
        end else begin
          m_snap <= m_mem[m_cur_addr[9:2]];
        end
        m_left <= m_wr[m_port] ? 0 : rd_stall;
        m_srv  <= 2;
      end else if (m_left == 0) begin
        if (!m_wr[m_port]) m_rdata[m_port] <= m_snap;
        m_pend[m_port] <= 1'b0;
        m_srv          <= 0;
      end else begin
        m_left <= m_left - 1;
      end
      if (cap[0]) begin
        m_pend[0] <= 1'b1; m_wr[0] <= (s0_wmask != 0);
        m_a[0] <= s0_addr; m_d[0] <= s0_wdata; m_m[0] <= s0_wmask;
      end
      if (cap[1]) begin
        m_pend[1] <= 1'b1; m_wr[1] <= (s1_wmask != 0);
        m_a[1] <= s1_addr; m_d[1] <= s1_wdata; m_m[1] <= s1_wmask;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("s0_rbusy", 32'(s0_rbusy), 32'(m_pend[0] & ~m_wr[0]));
      chk("s0_wbusy", 32'(s0_wbusy), 32'(m_pend[0] & m_wr[0]));
      chk("s1_rbusy", 32'(s1_rbusy), 32'(m_pend[1] & ~m_wr[1]));
      chk("s1_wbusy", 32'(s1_wbusy), 32'(m_pend[1] & m_wr[1]));
      chk("s0_rdata", s0_rdata, m_rdata[0]);
      chk("s1_rdata", s1_rdata, m_rdata[1]);
      chk("mem_rstrb", 32'(mem_rstrb), 32'(m_srv == 1 && !m_wr[m_port]));
      chk("mem_wmask", 32'(mem_wmask), (m_srv == 1 && m_wr[m_port]) ? 32'(m_m[m_port]) : 32'h0);
      chk("mem_addr", mem_addr, m_cur_addr);
      chk("mem_wdata", mem_wdata, m_cur_wdata);
    end
  end

  // Issue log per instance, plus strobe counts on the main memory side.
  logic [31:0] log_q [$];
  logic [31:0] fp_log [$];
  int          n_rstrb = 0, n_wm = 0;
  always @(negedge clk) begin
    if (mem_rstrb) n_rstrb <= n_rstrb + 1;
    if (mem_wmask != 0) n_wm <= n_wm + 1;
    if (mem_rstrb || mem_wmask != 0) log_q.push_back(mem_addr);
    if (f_mem_rstrb || f_mem_wmask != 0) fp_log.push_back(f_mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_busy();
    return s0_rbusy | s0_wbusy | s1_rbusy | s1_wbusy |
           f_s0_rbusy | f_s0_wbusy | f_s1_rbusy | f_s1_wbusy;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (any_busy() && n < 60) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(any_busy()), 32'h0);
  endtask

  task automatic chk_order(input string name, input logic [31:0] exp[$], input int base,
                           input bit fp);
    int sz = fp ? fp_log.size() : log_q.size();
    chk({name, "_len"}, 32'(sz - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < sz; i++)
      chk(name, fp ? fp_log[base + i] : log_q[base + i], exp[i]);
  endtask

  task automatic both_read(input logic [31:0] a0, input logic [31:0] a1);
    s0_addr = a0; s1_addr = a1; s0_rstrb = 1'b1; s1_rstrb = 1'b1;
    tick();
    s0_rstrb = 1'b0; s1_rstrb = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_q [$];
    int base, fbase, cnt0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();

    // Single read on port 0, latency check
    s0_addr = 32'h100; s0_rstrb = 1'b1;
    tick(); s0_rstrb = 1'b0;
    chk("t1_busy_T1", 32'(s0_rbusy), 32'h1);
    chk("t1_rstrb_T1", 32'(mem_rstrb), 32'h0);
    tick();
    chk("t1_rstrb_T2", 32'(mem_rstrb), 32'h1);
    chk("t1_addr_T2", mem_addr, 32'h100);
    tick();
    chk("t1_busy_T3", 32'(s0_rbusy), 32'h1);
    chk("t1_rstrb_T3", 32'(mem_rstrb), 32'h0);
    tick();
    chk("t1_busy_T4", 32'(s0_rbusy), 32'h0);
    chk("t1_rdata_T4", s0_rdata, 32'hDEADBEEF);
    chk("t1_s1_rdata", s1_rdata, 32'h0);
    wait_idle();
    pulse_reset();
    tick();

    // Simultaneous reads straight after reset: port 0 first
    base = log_q.size(); fbase = fp_log.size();
    both_read(32'h10, 32'h20);
    repeat (3) tick();
    chk("t2_s0_busy_T4", 32'(s0_rbusy), 32'h0);
    chk("t2_s1_busy_T4", 32'(s1_rbusy), 32'h1);
    chk("t2_s0_rdata", s0_rdata, 32'h11111111);
    wait_idle();
    chk("t2_s1_rdata", s1_rdata, 32'h22222222);
    exp_q = {32'h10, 32'h20};
    chk_order("t2_order", exp_q, base, 1'b0);

    // Repeated ties alternate
    base = log_q.size(); fbase = fp_log.size();
    both_read(32'h10, 32'h20); wait_idle();
    both_read(32'h10, 32'h20); wait_idle();
    exp_q = {32'h10, 32'h20, 32'h10, 32'h20};
    chk_order("t3_rr_ties", exp_q, base, 1'b0);
    chk_order("t3_fp_ties", exp_q, fbase, 1'b1);

    // Port 0 alone, then a tie: round-robin favours port 1, fixed priority keeps port 0
    base = log_q.size(); fbase = fp_log.size();
    s0_addr = 32'h10; s0_rstrb = 1'b1;
    tick(); s0_rstrb = 1'b0;
    wait_idle();
    both_read(32'h10, 32'h20); wait_idle();
    exp_q = {32'h10, 32'h20, 32'h10};
    chk_order("t3_rr_after", exp_q, base, 1'b0);
    exp_q = {32'h10, 32'h10, 32'h20};
    chk_order("t3_fp_after", exp_q, fbase, 1'b1);

    // Port 1 partial write, port 0 reads the same word a cycle later
    cnt0 = n_wm;
    s1_addr = 32'h40; s1_wdata = 32'hCAFEF00D; s1_wmask = 4'b0011;
    tick();
    s1_wmask = 4'b0000;
    chk("t4_s1_wbusy", 32'(s1_wbusy), 32'h1);
    s0_addr = 32'h40; s0_rstrb = 1'b1;
    tick(); s0_rstrb = 1'b0;
    wait_idle();
    chk("t4_rdata", s0_rdata, 32'h1234F00D);
    chk("t4_wmask_cycles", 32'(n_wm - cnt0), 32'h1);

    // Memory stalls a read for 5 cycles
    rd_stall = 5;
    cnt0 = n_rstrb;
    s0_addr = 32'h100; s0_rstrb = 1'b1;
    tick(); s0_rstrb = 1'b0;
    repeat (6) tick();
    chk("t5_mem_rbusy_T7", 32'(mem_rbusy), 32'h1);
    chk("t5_busy_T7", 32'(s0_rbusy), 32'h1);
    chk("t5_addr_T7", mem_addr, 32'h100);
    tick();
    chk("t5_mem_rbusy_T8", 32'(mem_rbusy), 32'h0);
    chk("t5_busy_T8", 32'(s0_rbusy), 32'h1);
    tick();
    chk("t5_busy_T9", 32'(s0_rbusy), 32'h0);
    chk("t5_rdata", s0_rdata, 32'hDEADBEEF);
    chk("t5_rstrb_count", 32'(n_rstrb - cnt0), 32'h1);
    wait_idle();

    // Reset while the read waits on memory
    rd_stall = 3;
    s0_addr = 32'h10; s0_rstrb = 1'b1;
    tick(); s0_rstrb = 1'b0;
    repeat (2) tick();
    chk("t6_busy_pre", 32'(s0_rbusy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy_rst", 32'(s0_rbusy), 32'h0);
    chk("t6_rstrb_rst", 32'(mem_rstrb), 32'h0);
    chk("t6_wmask_rst", 32'(mem_wmask), 32'h0);
    chk("t6_rdata_rst", s0_rdata, 32'h0);
    chk("t6_addr_rst", mem_addr, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    rd_stall = 0;
    tick();

    base = log_q.size();
    s1_addr = 32'h20; s1_rstrb = 1'b1;
    tick(); s1_rstrb = 1'b0;
    repeat (3) tick();
    chk("t6_s1_rdata", s1_rdata, 32'h22222222);
    chk("t6_s0_rdata", s0_rdata, 32'h0);
    wait_idle();
    both_read(32'h10, 32'h20); wait_idle();
    exp_q = {32'h20, 32'h10, 32'h20};
    chk_order("t6_order", exp_q, base, 1'b0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
